shift_arbiter: RTL and testbench
================================

SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter: DW, 32, datapath width in bits.
REQ-002 Parameter: SW, 5, shift-amount width (log2 DW).
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req0_valid  in  1  requester 0 presents an operation.
REQ-006 req0_ready  out  1  requester 0 operation accepted this cycle.
REQ-007 req0_op  in  2  shift_op_t: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-008 req0_num  in  DW  operand.
REQ-009 req0_shifts  in  SW  shift amount, 0..DW-1.
REQ-010 req1_valid, req1_ready, req1_op, req1_num, req1_shifts: same directions, widths and meanings as REQ-005..009, for requester 1.
REQ-011 rsp_valid  out  1  registered result available.
REQ-012 rsp_ready  in  1  consumer accepts the result.
REQ-013 rsp_id  out  1  index of the requester that owns the result.
REQ-014 rsp_data  out  DW  shifted result.
REQ-015 rsp_carry  out  1  last bit shifted out.

Function
REQ-016 FSM states: IDLE (output register empty) and HOLD (rsp_valid=1).
REQ-017 Accept condition: a request is accepted when (state==IDLE or rsp_ready==1) and it is granted; reqN_ready is 1 only for the granted requester, and only under that condition.
REQ-018 Round-robin: a priority pointer prio selects the preferred requester when both valids are 1; after a grant to k, prio becomes 1-k; a lone valid requester is granted regardless of prio.
REQ-019 Latency: the result of an operation accepted in cycle t appears on rsp_* in cycle t+1.
REQ-020 Transitions: IDLE->HOLD on accept. HOLD->IDLE when rsp_ready and no accept. HOLD->HOLD when a new accept coincides with rsp_ready (back-to-back, one result per cycle). HOLD->HOLD with outputs unchanged when rsp_ready=0.
REQ-021 While rsp_valid=1 and rsp_ready=0, rsp_id, rsp_data and rsp_carry shall stay stable and both ready outputs shall be 0.
REQ-022 LSL: data=num<<s; carry=num[DW-s].
REQ-023 LSR: zero-filled; carry=num[s-1].
REQ-024 ASR: bits above DW-1-s filled with num[DW-1]; carry=num[s-1].
REQ-025 ROR: data=(num>>s)|(num<<(DW-s)); carry=num[s-1].
REQ-026 s=0: data=num and carry=0 for every op.
REQ-027 Request inputs are sampled only on the accept cycle; changes on a non-accepted requester have no effect.
REQ-028 A requester that drops valid before being granted loses its turn; prio is not updated for it.

Reset
REQ-029 On rst=1, immediately and independently of clk: state=IDLE, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_carry=0, prio=0 (requester 0 preferred).
REQ-030 Reset asserted during HOLD shall discard the held result; no response for it is produced after release.
REQ-031 While rst=1, req0_ready and req1_ready shall be 0.

Structure
REQ-032 Package shift_pkg shall hold shift_op_t (OP_LSL, OP_LSR, OP_ASR, OP_ROR), DW and SW defaults, and the FSM state enum.
REQ-033 Shift arithmetic shall live in the combinational sub-module shift_core (op, num, shifts -> data, carry). shift_arbiter shall contain only arbitration, the FSM and the output register.

Verification
REQ-034 Requester 0 issues ASR num=0x80000000 s=4, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_data=0xF8000000, rsp_carry=0.
REQ-035 Both valid every cycle after reset (prio=0), rsp_ready=1 -> grants 0,1,0,1. Back-to-back rsp_valid=1 each cycle, with rsp_id alternating 0,1,0,1.
REQ-036 Requester 1 issues LSL num=0x80000001 s=1, rsp_ready=0 for 3 cycles -> rsp_data=0x00000002, rsp_carry=1 held stable and both ready=0. Result retires on the cycle rsp_ready rises.
REQ-037 Requester 0 issues ROR num=0x00000001 s=1 -> rsp_data=0x80000000, rsp_carry=1. LSR num=0xFFFFFFFF s=0 -> rsp_data=0xFFFFFFFF, rsp_carry=0.
REQ-038 rst pulsed mid-cycle while in HOLD -> rsp_valid falls without a clock edge. After release, requests from both requesters are granted to requester 0 first.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and default widths for the shift arbiter slice.
package shift_pkg;

  localparam int unsigned DefaultDw = 32;
  localparam int unsigned DefaultSw = 5;

  typedef enum logic [1:0] {
    OP_LSL = 2'b00,
    OP_LSR = 2'b01,
    OP_ASR = 2'b10,
    OP_ROR = 2'b11
  } shift_op_t;

  // StIdle: output register empty; StHold: rsp_valid asserted
  typedef enum logic {
    StIdle,
    StHold
  } state_t;

endpackage

// File: rtl/shift_core.sv
// Combinational shifter: LSL/LSR/ASR/ROR with last-bit-out carry.
module shift_core
  import shift_pkg::*;
#(
  parameter int unsigned DW = DefaultDw,
  parameter int unsigned SW = DefaultSw
) (
  input  shift_op_t       op,
  input  logic [DW-1:0]   num,
  input  logic [SW-1:0]   shifts,
  output logic [DW-1:0]   data,
  output logic            carry
);

  localparam logic [DW-1:0] MsbOne = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] LsbOne = {{(DW-1){1'b0}}, 1'b1};

  logic [SW-1:0] shifts_m1;
  logic          carry_left;
  logic          carry_right;

  // Carry is a single-bit select at num[DW-s] (left) or num[s-1] (right), built as masks
  assign shifts_m1   = shifts - SW'(1);
  assign carry_left  = |(num & (MsbOne >> shifts_m1));
  assign carry_right = |(num & (LsbOne << shifts_m1));

  // Select result and carry by op; a zero shift passes num through with no carry
  always_comb begin
    data  = num;
    carry = 1'b0;
    if (shifts != '0) begin
      unique case (op)
        OP_LSL: begin
          data  = num << shifts;
          carry = carry_left;
        end
        OP_LSR: begin
          data  = num >> shifts;
          carry = carry_right;
        end
        OP_ASR: begin
          data  = $unsigned($signed(num) >>> shifts);
          carry = carry_right;
        end
        OP_ROR: begin
          data  = (num >> shifts) | (num << (DW - shifts));
          carry = carry_right;
        end
        default: begin
          data  = num;
          carry = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end to a shared shifter with a registered response.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int unsigned DW = DefaultDw,
  parameter int unsigned SW = DefaultSw
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  shift_op_t       req0_op,
  input  logic [DW-1:0]   req0_num,
  input  logic [SW-1:0]   req0_shifts,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  shift_op_t       req1_op,
  input  logic [DW-1:0]   req1_num,
  input  logic [SW-1:0]   req1_shifts,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [DW-1:0]   rsp_data,
  output logic            rsp_carry
);

  state_t        state_q, state_d;
  logic          prio_q, prio_d;
  logic          accept;
  logic          grant_id;
  shift_op_t     sel_op;
  logic [DW-1:0] sel_num;
  logic [SW-1:0] sel_shifts;
  logic [DW-1:0] core_data;
  logic          core_carry;
  logic          rsp_id_q;
  logic [DW-1:0] rsp_data_q;
  logic          rsp_carry_q;

  // Arbitration, operand mux and FSM next state
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    // A lone valid wins regardless of prio; with both valid, prio decides
    if (req0_valid && req1_valid) begin
      grant_id = prio_q;
    end else begin
      grant_id = !req0_valid;
    end
    // Gated by rst so the readies drop immediately on an asynchronous reset
    accept = !rst && (req0_valid || req1_valid) && ((state_q == StIdle) || rsp_ready);
    req0_ready = accept && !grant_id;
    req1_ready = accept && grant_id;
    sel_op     = grant_id ? req1_op     : req0_op;
    sel_num    = grant_id ? req1_num    : req0_num;
    sel_shifts = grant_id ? req1_shifts : req0_shifts;
    if (accept) begin
      state_d = StHold;
      prio_d  = !grant_id;
    end else if (rsp_ready) begin
      state_d = StIdle;
    end
  end

  shift_core #(
    .DW (DW),
    .SW (SW)
  ) u_shift_core (
    .op     (sel_op),
    .num    (sel_num),
    .shifts (sel_shifts),
    .data   (core_data),
    .carry  (core_carry)
  );

  // State, priority pointer and response register; only an accept loads the response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      prio_q      <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      if (accept) begin
        rsp_id_q    <= grant_id;
        rsp_data_q  <= core_data;
        rsp_carry_q <= core_carry;
      end
    end
  end

  assign rsp_valid = (state_q == StHold);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed plus randomized bench for shift_arbiter against a bit-serial reference model.
module tb_shift_arbiter;
  import shift_pkg::*;

  localparam int DW = 32;
  localparam int SW = 5;

  logic          clk;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  shift_op_t     req0_op, req1_op;
  logic [DW-1:0] req0_num, req1_num;
  logic [SW-1:0] req0_shifts, req1_shifts;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_carry;
  logic [DW-1:0] rsp_data;

  shift_arbiter #(
    .DW (DW),
    .SW (SW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_op     (req0_op),
    .req0_num    (req0_num),
    .req0_shifts (req0_shifts),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_op     (req1_op),
    .req1_num    (req1_num),
    .req1_shifts (req1_shifts),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .rsp_carry   (rsp_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Model of the response register contents and the round-robin pointer
  logic          m_valid;
  logic          m_id;
  logic [DW-1:0] m_data;
  logic          m_carry;
  logic          m_prio;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One bit position per iteration, tracking the bit that falls off
  function automatic void ref_shift(input shift_op_t op, input logic [DW-1:0] num, input int s,
                                    output logic [DW-1:0] d, output logic c);
    d = num;
    c = 1'b0;
    for (int i = 0; i < s; i++) begin
      case (op)
        OP_LSL: begin c = d[DW-1]; d = {d[DW-2:0], 1'b0}; end
        OP_LSR: begin c = d[0]; d = {1'b0, d[DW-1:1]}; end
        OP_ASR: begin c = d[0]; d = {d[DW-1], d[DW-1:1]}; end
        default: begin c = d[0]; d = {d[0], d[DW-1:1]}; end
      endcase
    end
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_id    = 1'b0;
    m_data  = '0;
    m_carry = 1'b0;
    m_prio  = 1'b0;
  endtask

  task automatic drive(input logic v0, input shift_op_t o0, input logic [DW-1:0] n0,
                       input int s0, input logic v1, input shift_op_t o1,
                       input logic [DW-1:0] n1, input int s1, input logic rr);
    req0_valid  = v0;
    req0_op     = o0;
    req0_num    = n0;
    req0_shifts = SW'(s0);
    req1_valid  = v1;
    req1_op     = o1;
    req1_num    = n1;
    req1_shifts = SW'(s1);
    rsp_ready   = rr;
  endtask

  // Called just after a falling edge with inputs applied: check readies, clock, check response
  task automatic step(input string tag);
    logic      can_take;
    int        g;
    shift_op_t op;
    logic [DW-1:0] num, d;
    int        s;
    logic      c;
    #1;
    can_take = !m_valid || rsp_ready;
    if (req0_valid && req1_valid) g = int'(m_prio);
    else if (req0_valid) g = 0;
    else if (req1_valid) g = 1;
    else g = -1;
    if (!can_take) g = -1;
    check({tag, ".ready0"}, 64'(req0_ready), 64'(g == 0));
    check({tag, ".ready1"}, 64'(req1_ready), 64'(g == 1));
    op  = (g == 1) ? req1_op : req0_op;
    num = (g == 1) ? req1_num : req0_num;
    s   = (g == 1) ? int'(req1_shifts) : int'(req0_shifts);
    @(posedge clk);
    if (g >= 0) begin
      ref_shift(op, num, s, d, c);
      m_valid = 1'b1;
      m_id    = g[0];
      m_data  = d;
      m_carry = c;
      m_prio  = !g[0];
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    check({tag, ".valid"}, 64'(rsp_valid), 64'(m_valid));
    if (m_valid) begin
      check({tag, ".id"}, 64'(rsp_id), 64'(m_id));
      check({tag, ".data"}, 64'(rsp_data), 64'(m_data));
      check({tag, ".carry"}, 64'(rsp_carry), 64'(m_carry));
    end
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    drive(1'b0, OP_LSL, '0, 0, 1'b0, OP_LSL, '0, 0, 1'b0);
    #1;
    check("reset.valid", 64'(rsp_valid), 64'(0));
    check("reset.id", 64'(rsp_id), 64'(0));
    check("reset.data", 64'(rsp_data), 64'(0));
    check("reset.carry", 64'(rsp_carry), 64'(0));
    drive(1'b1, OP_LSL, 32'h1, 1, 1'b1, OP_LSL, 32'h1, 1, 1'b1);
    #1;
    check("reset.ready0", 64'(req0_ready), 64'(0));
    check("reset.ready1", 64'(req1_ready), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Both valid every cycle after reset: grants alternate starting with requester 0
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, OP_LSL, 32'h10 + DW'(i), 1, 1'b1, OP_LSR, 32'h20 + DW'(i), 1, 1'b1);
      step("rr");
      check("rr.id_seq", 64'(rsp_id), 64'(i % 2));
      check("rr.valid_seq", 64'(rsp_valid), 64'(1));
    end

    // Requester 0 ASR of the sign bit
    drive(1'b1, OP_ASR, 32'h8000_0000, 4, 1'b0, OP_LSL, '0, 0, 1'b1);
    step("asr");
    check("asr.data_k", 64'(rsp_data), 64'h0000_0000_F800_0000);
    check("asr.carry_k", 64'(rsp_carry), 64'(0));
    check("asr.id_k", 64'(rsp_id), 64'(0));

    // Requester 1 LSL held under backpressure, retires when rsp_ready rises
    drive(1'b0, OP_LSL, '0, 0, 1'b1, OP_LSL, 32'h8000_0001, 1, 1'b1);
    step("lsl");
    check("lsl.data_k", 64'(rsp_data), 64'h0000_0000_0000_0002);
    check("lsl.carry_k", 64'(rsp_carry), 64'(1));
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, OP_ROR, 32'hDEAD_0000 + DW'(i), 3, 1'b1, OP_LSR, 32'hBEEF, 2, 1'b0);
      step("hold");
      check("hold.data_k", 64'(rsp_data), 64'h0000_0000_0000_0002);
      check("hold.id_k", 64'(rsp_id), 64'(1));
    end
    drive(1'b0, OP_LSL, '0, 0, 1'b0, OP_LSL, '0, 0, 1'b1);
    step("retire");
    check("retire.valid_k", 64'(rsp_valid), 64'(0));

    // Rotate wraps bit 0 to the top; zero shift passes through
    drive(1'b1, OP_ROR, 32'h0000_0001, 1, 1'b0, OP_LSL, '0, 0, 1'b1);
    step("ror");
    check("ror.data_k", 64'(rsp_data), 64'h0000_0000_8000_0000);
    check("ror.carry_k", 64'(rsp_carry), 64'(1));
    drive(1'b1, OP_LSR, 32'hFFFF_FFFF, 0, 1'b0, OP_LSL, '0, 0, 1'b1);
    step("lsr0");
    check("lsr0.data_k", 64'(rsp_data), 64'h0000_0000_FFFF_FFFF);
    check("lsr0.carry_k", 64'(rsp_carry), 64'(0));

    // Reset mid-cycle while holding: response drops with no clock edge
    drive(1'b0, OP_LSL, '0, 0, 1'b1, OP_LSL, 32'h3, 2, 1'b0);
    step("prehold");
    drive(1'b1, OP_LSL, 32'h5, 1, 1'b1, OP_LSL, 32'h7, 1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("arst.valid", 64'(rsp_valid), 64'(0));
    check("arst.data", 64'(rsp_data), 64'(0));
    check("arst.ready0", 64'(req0_ready), 64'(0));
    check("arst.ready1", 64'(req1_ready), 64'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, OP_LSL, 32'h5, 1, 1'b1, OP_LSL, 32'h7, 1, 1'b1);
    step("postrst");
    check("postrst.id_k", 64'(rsp_id), 64'(0));

    // Randomized traffic with backpressure, biased toward boundary shift amounts
    for (int i = 0; i < 400; i++) begin
      int s0, s1;
      s0 = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : DW - 1)
                                       : int'($urandom_range(0, DW - 1));
      s1 = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : DW - 1)
                                       : int'($urandom_range(0, DW - 1));
      drive($urandom_range(0, 3) != 0, shift_op_t'($urandom_range(0, 3)), DW'($urandom()), s0,
            $urandom_range(0, 3) != 0, shift_op_t'($urandom_range(0, 3)), DW'($urandom()), s1,
            $urandom_range(0, 2) != 0);
      step("rand");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
